d_mem_bridge: RTL
=================

Name: d_mem_bridge

Overview:
Data-side bus bridge directly downstream of the core's d_mem_* port. It accepts one 16-bit request at a time, with per-byte enables, from the core. It turns each request into one or two byte cycles on an 8-bit external memory bus that has a req/ack handshake, and returns read data and ready to the core.

Parameters:
BIG_ENDIAN, 0, 0 = low byte of a word at even address, 1 = high byte at even address
TIMEOUT_CYCLES, 255, byte-cycle wait limit before abort (used only with D_BRIDGE_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
a_rst  in  1  asynchronous reset, active-high
d_mem_assert  in  1  core request valid
d_mem_cmd  in  1  1 = write, 0 = read
d_mem_be0  in  1  low lane enable
d_mem_be1  in  1  high lane enable
d_mem_addr  in  16  byte address
d_mem_data_out  in  16  core write data
d_mem_data_in  out  16  read data to core
d_mem_rdy  out  1  bridge idle / request complete
ext_req  out  1  byte cycle request
ext_we  out  1  byte cycle is a write
ext_addr  out  16  byte address
ext_wdata  out  8  byte write data
ext_rdata  in  8  byte read data
ext_ack  in  1  byte cycle complete, sampled on rising clk
bus_err  out  1  sticky timeout flag (constant 0 without D_BRIDGE_TIMEOUT_EN)

Behaviour:
- Reset (async, immediate): state IDLE, d_mem_rdy=1, ext_req=0, ext_we=0, ext_addr=0, ext_wdata=0, d_mem_data_in=0, bus_err=0.
- d_mem_rdy is registered and equals (state==IDLE).
- Accept: at a rising edge in IDLE with d_mem_assert=1, latch addr, cmd, be0, be1 and data_out. In any other state d_mem_assert is ignored; the core holds it.
- Access kind:
  - WORD (be0&be1): two byte cycles at {addr[15:1],0} then {addr[15:1],1}.
    - BIG_ENDIAN=0: first byte <-> data[7:0], second byte <-> data[15:8].
    - BIG_ENDIAN=1: the lanes are swapped.
  - BYTE (exactly one enable): one cycle at addr unchanged. Write data is taken from data_out[7:0]. Read data is zero-extended into d_mem_data_in[15:0].
  - NONE (no enable): no external cycle. Go to IDLE on the next edge; d_mem_data_in is unchanged.
- States:
  - IDLE -> B0 on accept (NONE goes to a one-cycle NOP state, then IDLE).
  - B0: ext_req=1, and addr/we/wdata are stable. On ext_ack: WORD -> B1, otherwise -> IDLE.
  - B1: ext_req=1 with the second byte. On ext_ack -> IDLE.
- ext_req, ext_addr, ext_we and ext_wdata are registered. They change only on state transitions and never glitch while ext_req=1.
- Between B0 and B1, ext_req stays 1. The address and data change on the same edge that samples the first ack.
- Read capture: each read byte is latched into a holding register on its ack. d_mem_data_in is updated on the edge that enters IDLE, so the whole word appears at once, and it holds until the next read completes. Writes never modify d_mem_data_in.
- Latency with ext_ack tied high: BYTE keeps rdy low 1 cycle, WORD 2 cycles. Each wait cycle (ack=0) adds one cycle.
- Back-to-back requests: a new request can be accepted on the first edge where rdy=1 (one IDLE cycle minimum between requests).
- Unaligned WORD: addr[0] is ignored, and the access is forced aligned.
- Reset mid-operation: the cycle is abandoned, ext_req drops immediately, and no partial data reaches d_mem_data_in.

Optional Feature:
D_BRIDGE_TIMEOUT_EN:
- With the macro defined: an 8+-bit wait counter clears on every state entry and increments each cycle in B0/B1 with ext_ack=0. When it reaches TIMEOUT_CYCLES, the bridge drops ext_req, sets bus_err (sticky until reset) and goes to IDLE. A timed-out read returns 16'hFFFF. A timed-out WORD skips its second byte.
- Without the macro: there is no counter, the bridge waits forever, and bus_err is tied to 0.

Decomposition:
- Package d_mem_bridge_pkg holds:
  - the state enum (IDLE, NOP, B0, B1);
  - the access-kind enum (NONE, BYTE, WORD);
  - the CMD_WRITE=1 constant;
  - the timeout read value 16'hFFFF.
- One natural sub-module: d_mem_lane_mux (combinational). It computes the byte address, write byte and read-lane placement from kind, step, addr[0] and BIG_ENDIAN.
- The FSM stays in the top module.

Test Plan:
1. Reset, ack tied 1, WORD read at 16'h00A0 (bytes A0=8'h12, A1=8'h34) -> rdy low 2 cycles; ext_addr A0 then A1; d_mem_data_in=16'h3412; with BIG_ENDIAN=1 the result is 16'h1234.
2. WORD write 16'hBEEF at 16'h00A3 -> two write cycles: 00A2 gets 8'hEF, 00A3 gets 8'hBE; d_mem_data_in unchanged.
3. BYTE read be1-only at 16'h00A1 (8'h34), ack delayed 3 cycles -> single cycle at 00A1; rdy low 4 cycles; d_mem_data_in=16'h0034.
4. Back-to-back: BYTE write then WORD read with d_mem_assert held -> second request accepted exactly one IDLE cycle after the first completes; no overlap of ext_req.
5. Assert a_rst while in B1 of a WORD read -> ext_req=0 and rdy=1 immediately; d_mem_data_in=0; the next request works normally.
6. D_BRIDGE_TIMEOUT_EN, TIMEOUT_CYCLES=4, ack held 0 on a read -> abort after 4 wait cycles; bus_err=1; d_mem_data_in=16'hFFFF; rdy=1.

Source files
------------

// File: rtl/d_mem_bridge_pkg.sv
// Shared types and constants for the 16-bit to 8-bit data-side memory bridge.
package d_mem_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    NOP  = 2'd1,
    B0   = 2'd2,
    B1   = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    BYTE = 2'd1,
    WORD = 2'd2
  } kind_t;

  localparam logic        CMD_WRITE     = 1'b1;
  localparam logic [15:0] TIMEOUT_RDATA = 16'hFFFF;

  function automatic kind_t access_kind(input logic be0, input logic be1);
    if (be0 && be1) begin
      return WORD;
    end else if (be0 || be1) begin
      return BYTE;
    end else begin
      return NONE;
    end
  endfunction

endpackage

// File: rtl/d_mem_lane_mux.sv
// Byte-lane steering: external byte address and write byte for the step being
// issued, and placement of a returned read byte into the 16-bit word.
module d_mem_lane_mux
  import d_mem_bridge_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
) (
  input  kind_t       kind,
  input  logic        issue_step,
  input  logic        capture_step,
  input  logic [15:0] addr,
  input  logic [15:0] wdata,
  input  logic [15:0] hold,
  input  logic [7:0]  rdata,
  output logic [15:0] byte_addr,
  output logic [7:0]  byte_wdata,
  output logic [15:0] rd_word
);

  logic issue_upper;
  logic capture_upper;

  // Upper-lane selection for WORD accesses: step 0 is the even byte.
  assign issue_upper   = issue_step ^ BIG_ENDIAN;
  assign capture_upper = capture_step ^ BIG_ENDIAN;

  // Lane steering per access kind; BYTE and NONE use the low lane as-is.
  always_comb begin
    byte_addr  = addr;
    byte_wdata = wdata[7:0];
    rd_word    = {8'h00, rdata};
    case (kind)
      WORD: begin
        byte_addr  = {addr[15:1], issue_step};
        byte_wdata = issue_upper ? wdata[15:8] : wdata[7:0];
        rd_word    = capture_upper ? {rdata, hold[7:0]} : {hold[15:8], rdata};
      end
      BYTE: begin
        byte_addr  = addr;
        byte_wdata = wdata[7:0];
        rd_word    = {8'h00, rdata};
      end
      default: begin
        byte_addr  = addr;
        byte_wdata = wdata[7:0];
        rd_word    = {8'h00, rdata};
      end
    endcase
  end

endmodule

// File: rtl/d_mem_bridge.sv
// Core data port to 8-bit req/ack memory bus bridge. Optional bus-cycle timeout
// (and the TIMEOUT_CYCLES parameter) is enabled by defining D_BRIDGE_TIMEOUT_EN.
module d_mem_bridge
  import d_mem_bridge_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b0
`ifdef D_BRIDGE_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 255
`endif
) (
  input  logic        clk,
  input  logic        a_rst,
  input  logic        d_mem_assert,
  input  logic        d_mem_cmd,
  input  logic        d_mem_be0,
  input  logic        d_mem_be1,
  input  logic [15:0] d_mem_addr,
  input  logic [15:0] d_mem_data_out,
  output logic [15:0] d_mem_data_in,
  output logic        d_mem_rdy,
  output logic        ext_req,
  output logic        ext_we,
  output logic [15:0] ext_addr,
  output logic [7:0]  ext_wdata,
  input  logic [7:0]  ext_rdata,
  input  logic        ext_ack,
  output logic        bus_err
);

  state_t      state;
  state_t      state_next;
  kind_t       kind_q;
  kind_t       src_kind;
  logic        cmd_q;
  logic        src_cmd;
  logic [15:0] addr_q;
  logic [15:0] src_addr;
  logic [15:0] data_q;
  logic [15:0] src_data;
  logic [15:0] hold;
  logic [15:0] byte_addr;
  logic [7:0]  byte_wdata;
  logic [15:0] rd_word;
  logic        in_bus;
  logic        issue_load;
  logic        capture;
  logic        read_done;
  logic        timeout_hit;
  logic        timeout_rd;

  // In IDLE the request is taken straight from the core so the first byte
  // cycle can be registered on the accepting edge.
  assign src_kind = (state == IDLE) ? access_kind(d_mem_be0, d_mem_be1) : kind_q;
  assign src_cmd  = (state == IDLE) ? d_mem_cmd      : cmd_q;
  assign src_addr = (state == IDLE) ? d_mem_addr     : addr_q;
  assign src_data = (state == IDLE) ? d_mem_data_out : data_q;

  assign in_bus     = (state == B0) || (state == B1);
  assign issue_load = ((state_next == B0) && (state != B0)) ||
                      ((state_next == B1) && (state != B1));
  assign capture    = in_bus && ext_ack && (cmd_q != CMD_WRITE);
  assign read_done  = capture && (state_next == IDLE);
  assign timeout_rd = timeout_hit && (cmd_q != CMD_WRITE);

  d_mem_lane_mux #(
    .BIG_ENDIAN (BIG_ENDIAN)
  ) u_lane_mux (
    .kind         (src_kind),
    .issue_step   (state_next == B1),
    .capture_step (state == B1),
    .addr         (src_addr),
    .wdata        (src_data),
    .hold         (hold),
    .rdata        (ext_rdata),
    .byte_addr    (byte_addr),
    .byte_wdata   (byte_wdata),
    .rd_word      (rd_word)
  );

  // Next-state logic; an ack always wins over a timeout on the same cycle.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (d_mem_assert) begin
          state_next = (access_kind(d_mem_be0, d_mem_be1) == NONE) ? NOP : B0;
        end else begin
          state_next = IDLE;
        end
      end
      NOP: state_next = IDLE;
      B0: begin
        if (ext_ack) begin
          state_next = (kind_q == WORD) ? B1 : IDLE;
        end else if (timeout_hit) begin
          state_next = IDLE;
        end else begin
          state_next = B0;
        end
      end
      B1: begin
        if (ext_ack || timeout_hit) begin
          state_next = IDLE;
        end else begin
          state_next = B1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // State, request latch and registered bus/core outputs.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state     <= IDLE;
      d_mem_rdy <= 1'b1;
      kind_q    <= NONE;
      cmd_q     <= 1'b0;
      addr_q    <= 16'h0000;
      data_q    <= 16'h0000;
      ext_req   <= 1'b0;
      ext_we    <= 1'b0;
      ext_addr  <= 16'h0000;
      ext_wdata <= 8'h00;
      hold      <= 16'h0000;
    end else begin
      state     <= state_next;
      d_mem_rdy <= (state_next == IDLE);
      ext_req   <= (state_next == B0) || (state_next == B1);
      if ((state == IDLE) && d_mem_assert) begin
        kind_q <= src_kind;
        cmd_q  <= d_mem_cmd;
        addr_q <= d_mem_addr;
        data_q <= d_mem_data_out;
      end
      if (issue_load) begin
        ext_addr  <= byte_addr;
        ext_wdata <= byte_wdata;
        ext_we    <= (src_cmd == CMD_WRITE);
      end
      if (capture) begin
        hold <= rd_word;
      end
    end
  end

  // The core only sees a read word once the whole access has finished.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      d_mem_data_in <= 16'h0000;
    end else if (read_done) begin
      d_mem_data_in <= rd_word;
    end else if (timeout_rd) begin
      d_mem_data_in <= TIMEOUT_RDATA;
    end
  end

`ifdef D_BRIDGE_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;

  logic [CW-1:0] wait_cnt;

  assign timeout_hit = in_bus && !ext_ack && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter restarts whenever a byte cycle is acked or the state changes.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      wait_cnt <= '0;
      bus_err  <= 1'b0;
    end else begin
      if (in_bus && !ext_ack && !timeout_hit) begin
        wait_cnt <= wait_cnt + CW'(1);
      end else begin
        wait_cnt <= '0;
      end
      if (timeout_hit) begin
        bus_err <= 1'b1;
      end
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign bus_err     = 1'b0;
`endif

endmodule
